// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- datapath ALU of the 8-bit CPU.
//
// Computes one of eight logic/arithmetic operations on a and b
// combinationally. The result and the carry, zero and overflow flags are
// registered, so the outputs follow the inputs with one cycle of latency.
// A new operation is accepted on every rising clock edge.
//
// Ports
//   clk    in   1      system clock, rising-edge active
//   rst_n  in   1      asynchronous active-low reset
//   a      in   WIDTH  operand A (sole operand for NOT/INC/DEC)
//   b      in   WIDTH  operand B (ignored for NOT/INC/DEC)
//   op     in   3      operation select:
//                      000 AND, 001 OR, 010 XOR, 011 NOT,
//                      100 ADD, 101 SUB, 110 INC, 111 DEC
//   res    out  WIDTH  registered result
//   c_out  out  1      registered carry (ADD/INC) or borrow (SUB/DEC)
//   zero   out  1      registered zero flag, 1 iff res == 0
//   ovf    out  1      registered two's-complement overflow flag
// -----------------------------------------------------------------------------
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] res,
  output logic             c_out,
  output logic             zero,
  output logic             ovf
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_INC = 3'b110;
  localparam logic [2:0] OP_DEC = 3'b111;

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  // Signed overflow of an addition s = x + y: same-sign operands, result sign
  // differs. Subtraction x - y is checked as x + (-y), i.e. with y's sign
  // inverted, which gives "signs differ and result sign != sign of x".
  function automatic logic add_ovf(input logic x_msb, input logic y_msb,
                                   input logic s_msb);
    add_ovf = (x_msb == y_msb) && (s_msb != x_msb);
  endfunction

  logic [WIDTH-1:0] res_d, res_q;
  logic             c_d, c_q;
  logic             ovf_d, ovf_q;
  logic             zero_q;

  // Extended by one bit so that bit WIDTH carries the carry or borrow.
  logic [WIDTH:0] sum_x, diff_x, inc_x, dec_x;

  assign sum_x  = {1'b0, a} + {1'b0, b};
  assign diff_x = {1'b0, a} - {1'b0, b};
  assign inc_x  = {1'b0, a} + ONE;
  assign dec_x  = {1'b0, a} - ONE;

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    ovf_d = 1'b0;
    unique case (op)
      OP_AND: res_d = a & b;
      OP_OR:  res_d = a | b;
      OP_XOR: res_d = a ^ b;
      OP_NOT: res_d = ~a;
      OP_ADD: begin
        res_d = sum_x[WIDTH-1:0];
        c_d   = sum_x[WIDTH];
        ovf_d = add_ovf(a[WIDTH-1], b[WIDTH-1], sum_x[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = diff_x[WIDTH-1:0];
        c_d   = diff_x[WIDTH];
        ovf_d = add_ovf(a[WIDTH-1], ~b[WIDTH-1], diff_x[WIDTH-1]);
      end
      // +1 is positive, so overflow only when a is the largest positive value.
      OP_INC: begin
        res_d = inc_x[WIDTH-1:0];
        c_d   = inc_x[WIDTH];
        ovf_d = add_ovf(a[WIDTH-1], 1'b0, inc_x[WIDTH-1]);
      end
      // -1 is negative, so overflow only when a is the most negative value.
      OP_DEC: begin
        res_d = dec_x[WIDTH-1:0];
        c_d   = dec_x[WIDTH];
        ovf_d = add_ovf(a[WIDTH-1], 1'b1, dec_x[WIDTH-1]);
      end
      default: ;
    endcase
  end

  // ---- register stage: result and flags ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      c_q    <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      res_q  <= res_d;
      c_q    <= c_d;
      ovf_q  <= ovf_d;
      zero_q <= (res_d == '0);
    end
  end

  assign res   = res_q;
  assign c_out = c_q;
  assign zero  = zero_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu (WIDTH=8).
// Table of directed vectors with hand-computed expectations, plus hand-written
// sequences for reset and asynchronous reset in the middle of operation.
// -----------------------------------------------------------------------------
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic [7:0] res;
  logic       c_out;
  logic       zero;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  alu #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .op    (op),
    .res   (res),
    .c_out (c_out),
    .zero  (zero),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       v;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [7:0] er, input logic ec,
                       input logic ez, input logic ev);
    total++;
    if (res !== er || c_out !== ec || zero !== ez || ovf !== ev) begin
      bad++;
      $display("FAIL %s: got res=%h c=%b z=%b v=%b, want res=%h c=%b z=%b v=%b",
               nm, res, c_out, zero, ovf, er, ec, ez, ev);
    end
  endtask

  initial begin
    //            op      a      b      res    c     z     v
    vecs[0]  = '{3'b000, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0, 1'b0}; // AND
    vecs[1]  = '{3'b001, 8'hCC, 8'hAA, 8'hEE, 1'b0, 1'b0, 1'b0}; // OR
    vecs[2]  = '{3'b010, 8'hCC, 8'hAA, 8'h66, 1'b0, 1'b0, 1'b0}; // XOR
    vecs[3]  = '{3'b011, 8'h0F, 8'h55, 8'hF0, 1'b0, 1'b0, 1'b0}; // NOT
    vecs[4]  = '{3'b000, 8'hCC, 8'h33, 8'h00, 1'b0, 1'b1, 1'b0}; // AND -> zero
    vecs[5]  = '{3'b010, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0}; // XOR -> zero
    vecs[6]  = '{3'b100, 8'd50, 8'd20, 8'd70, 1'b0, 1'b0, 1'b0}; // ADD
    vecs[7]  = '{3'b100, 8'd200,8'd100,8'd44, 1'b1, 1'b0, 1'b0}; // ADD carry
    vecs[8]  = '{3'b100, 8'd100,8'd100,8'd200,1'b0, 1'b0, 1'b1}; // ADD ovf
    vecs[9]  = '{3'b100, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1}; // ADD neg ovf
    vecs[10] = '{3'b101, 8'd100,8'd40, 8'd60, 1'b0, 1'b0, 1'b0}; // SUB
    vecs[11] = '{3'b101, 8'd40, 8'd100,8'd196,1'b1, 1'b0, 1'b0}; // SUB borrow
    vecs[12] = '{3'b101, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1}; // SUB ovf
    vecs[13] = '{3'b101, 8'd5,  8'd5,  8'd0,  1'b0, 1'b1, 1'b0}; // SUB zero
    vecs[14] = '{3'b101, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1}; // SUB 127-(-1)
    vecs[15] = '{3'b110, 8'd99, 8'hA5, 8'd100,1'b0, 1'b0, 1'b0}; // INC (b ignored)
    vecs[16] = '{3'b110, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0}; // INC wrap
    vecs[17] = '{3'b110, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b0, 1'b1}; // INC ovf
    vecs[18] = '{3'b111, 8'd5,  8'hFF, 8'd4,  1'b0, 1'b0, 1'b0}; // DEC
    vecs[19] = '{3'b111, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0}; // DEC wrap
    vecs[20] = '{3'b111, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1}; // DEC ovf
    vecs[21] = '{3'b111, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0}; // DEC -> zero

    rst_n = 1'b0;
    a     = 8'hCC;
    b     = 8'hAA;
    op    = 3'b001;

    // Reset held with clock running: edges must be ignored.
    repeat (3) @(posedge clk);
    #1 check("reset", 8'h00, 1'b0, 1'b1, 1'b0);

    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      op = vecs[i].op;
      a  = vecs[i].a;
      b  = vecs[i].b;
      @(posedge clk);
      #1 check($sformatf("vec%0d_op%0d", i, vecs[i].op),
               vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].v);
    end

    // Back-to-back ops: each edge captures the new op, flags do not stick.
    @(negedge clk); op = 3'b100; a = 8'd200; b = 8'd100;
    @(posedge clk);
    #1 check("pre_async", 8'd44, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges: outputs clear without a clock edge.
    #2 rst_n = 1'b0;
    op = 3'b001; a = 8'h0F; b = 8'hF0;
    #1 check("async_clear", 8'h00, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 check("async_hold", 8'h00, 1'b0, 1'b1, 1'b0);

    // First edge after release captures the current inputs.
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("after_release", 8'hFF, 1'b0, 1'b0, 1'b0);

    @(negedge clk); op = 3'b111; a = 8'h00; b = 8'h00;
    @(posedge clk);
    #1 check("post_release_dec", 8'hFF, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the sequence above is a fixed number of cycles.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish within 20000 time units");
    $fatal(1);
  end

endmodule
